// File: rtl/parity_stream_chk_if.sv
// Stream bundle for parity_stream_chk: the input beat channel (data, expected
// parity, per-beat mode bits) and the output result channel, each carried by
// a valid/ready handshake. The slave view is the checker, the master view is
// whatever produces input beats and consumes results.
interface parity_stream_chk_if #(
    parameter int DATA_WIDTH = 1024,
    parameter int LANE_WIDTH = 64
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    // Input channel
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [NUM_LANES-1:0]  in_par;
    logic                  mode_odd;
    logic                  check_en;

    // Output channel
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_LANES-1:0]  out_par;
    logic [NUM_LANES-1:0]  out_err;

    modport master (
        output in_valid, in_data, in_par, mode_odd, check_en, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_err
    );

    modport slave (
        input  in_valid, in_data, in_par, mode_odd, check_en, out_ready,
        output in_ready, out_valid, out_data, out_par, out_err
    );
endinterface

// File: rtl/parity_stream_chk.sv
// Two-stage streaming per-lane parity generator/checker. Stage 1 registers the
// accepted beat together with its mode bits; stage 2 registers the per-lane
// parity and mismatch flags that drive the output channel. Both stages use a
// skid-free "advance when the next stage can take it" rule, so a full pipe
// streams one beat per cycle and a stall back-propagates combinationally to
// in_ready. Error beats are counted once, at the output handshake.
module parity_stream_chk #(
    parameter int DATA_WIDTH = 1024,
    parameter int LANE_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_stream_chk_if.slave   bus,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_count,
    input  logic                 clr_err
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    // Stage 1: captured input beat
    logic                  v1;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [NUM_LANES-1:0]  s1_par;
    logic                  s1_mode_odd;
    logic                  s1_check_en;

    // Stage 2: result presented on the output channel
    logic                  v2;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [NUM_LANES-1:0]  s2_par;
    logic [NUM_LANES-1:0]  s2_err;

    // Handshake / advance terms
    logic adv1;
    logic adv2;
    logic out_fire;
    logic err_beat;

    // Combinational results computed from stage 1
    logic [NUM_LANES-1:0] lane_par;
    logic [NUM_LANES-1:0] lane_err;

    // A stage may load when it is empty or its current content leaves this cycle.
    assign adv2 = !v2 || bus.out_ready;
    assign adv1 = !v1 || adv2;

    assign bus.in_ready  = adv1 && !rst;
    assign bus.out_valid = v2;
    assign bus.out_data  = s2_data;
    assign bus.out_par   = s2_par;
    assign bus.out_err   = s2_err;

    assign out_fire = v2 && bus.out_ready;
    assign err_beat = out_fire && (|s2_err);

    // Per-lane parity of the stage-1 beat and its comparison against the supplied parity.
    always_comb begin
        // NOTE: every comb output gets a default before the loop so no path leaves it unassigned (no latch).
        lane_par = '0;
        lane_err = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_par[i] = (^s1_data[i*LANE_WIDTH +: LANE_WIDTH]) ^ s1_mode_odd;
        end
        if (s1_check_en) begin
            lane_err = lane_par ^ s1_par;
        end
    end

    // Stage 1 register: accept a new beat whenever the stage can advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: only the valid flag is reset here; the payload is don't-care while v1=0.
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data     <= bus.in_data;
                s1_par      <= bus.in_par;
                s1_mode_odd <= bus.mode_odd;
                s1_check_en <= bus.check_en;
            end
        end
    end

    // Stage 2 register: load the computed result; hold everything while stalled or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            s2_data <= '0;
            s2_par  <= '0;
            s2_err  <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_data <= s1_data;
                s2_par  <= lane_par;
                s2_err  <= lane_err;
            end
        end
    end

    // Error bookkeeping: count error beats at the output handshake, saturating; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (err_beat) begin
            err_sticky <= 1'b1;
            if (err_count != {CNT_WIDTH{1'b1}}) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_parity_stream_chk.sv
// Self-checking bench for parity_stream_chk (128-bit word, 4 lanes of 32 bits,
// 3-bit error counter). Stimulus pushes the expected result of each accepted
// beat into a queue; a monitor on the falling edge pops and compares every
// delivered beat, tracks the error counter and checks stall stability.
module tb_parity_stream_chk;
    localparam int DW  = 128;
    localparam int LW  = 32;
    localparam int NL  = DW / LW;
    localparam int CW  = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [NL-1:0] par;
        logic [NL-1:0] err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_err = 1'b0;
    logic          err_sticky;
    logic [CW-1:0] err_count;

    parity_stream_chk_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW)) bus ();

    parity_stream_chk #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    bit   armed = 1'b0;
    int   m_cnt = 0;
    bit   m_sticky = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: parity of a lane is the count of ones modulo 2, inverted in odd mode.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [NL-1:0] p,
                                   input logic m, input logic c);
        exp_t e;
        logic [LW-1:0] lane;
        e.data = d;
        for (int i = 0; i < NL; i++) begin
            lane = d[i*LW +: LW];
            e.par[i] = 1'(($countones(lane) % 2 == 1) ? 1 : 0) ^ m;
        end
        e.err = c ? (e.par ^ p) : '0;
        return e;
    endfunction

    // Drive one beat and hold it until accepted; expected result is queued on acceptance.
    task automatic send(input logic [DW-1:0] d, input logic [NL-1:0] p, input logic m, input logic c);
        bit ok = 1'b0;
        int cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_par   = p;
        bus.mode_odd = m;
        bus.check_en = c;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (ok) sb_q.push_back(model(d, p, m, c));
        else check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    // Let every queued beat leave, then settle one more edge so counters are final.
    task automatic drain();
        int cyc = 0;
        bus.out_ready = 1'b1;
        while (sb_q.size() != 0 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_timeout", 128'(sb_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard compare, counter model and stall stability.
    exp_t          cur;
    bit            hold = 1'b0;
    logic [DW-1:0] h_data;
    logic [NL-1:0] h_par;
    logic [NL-1:0] h_err;

    always @(negedge clk) begin
        if (armed) begin
            check("err_count", 128'(err_count), 128'(m_cnt));
            check("err_sticky", 128'(err_sticky), 128'(m_sticky));
            if (rst) begin
                sb_q.delete();
                m_cnt    = 0;
                m_sticky = 1'b0;
                hold     = 1'b0;
            end else begin
                if (hold) begin
                    check("stall_valid", 128'(bus.out_valid), 1);
                    check("stall_data", bus.out_data, h_data);
                    check("stall_par", 128'(bus.out_par), 128'(h_par));
                    check("stall_err", 128'(bus.out_err), 128'(h_err));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", 128'(bus.out_valid), 0);
                    end else begin
                        cur = sb_q.pop_front();
                        check("out_data", bus.out_data, cur.data);
                        check("out_par", 128'(bus.out_par), 128'(cur.par));
                        check("out_err", 128'(bus.out_err), 128'(cur.err));
                        if (cur.err != '0) begin
                            m_sticky = 1'b1;
                            if (m_cnt < CNT_MAX) m_cnt++;
                        end
                    end
                end
                if (clr_err) begin
                    m_cnt    = 0;
                    m_sticky = 1'b0;
                end
                hold   = bus.out_valid && !bus.out_ready;
                h_data = bus.out_data;
                h_par  = bus.out_par;
                h_err  = bus.out_err;
            end
        end
    end

    bit rand_done;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_par    = '0;
        bus.mode_odd  = 1'b0;
        bus.check_en  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_err_count", 128'(err_count), 0);
        check("rst_in_ready_after", 128'(bus.in_ready), 1);
        armed = 1'b1;
        @(posedge clk);
        #1;

        // Even generate with two-cycle latency
        send(128'h1, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_not_yet", 128'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_valid", 128'(bus.out_valid), 1);
        check("even_par", 128'(bus.out_par), 128'(4'b0001));
        check("even_data", bus.out_data, 128'h1);
        check("even_err", 128'(bus.out_err), 0);
        drain();

        // Odd mode, then even on a lane with four ones
        send(128'h0, 4'b0000, 1'b1, 1'b0);
        send(128'hF, 4'b0000, 1'b0, 1'b0);
        drain();

        // Check mode: one error beat counted, then same beat unchecked
        send(128'h3, 4'b0001, 1'b0, 1'b1);
        drain();
        check("chk_count", 128'(err_count), 1);
        check("chk_sticky", 128'(err_sticky), 1);
        send(128'h3, 4'b0001, 1'b0, 1'b0);
        drain();
        check("nochk_count", 128'(err_count), 1);

        // Backpressure: 5 beats, 3-cycle stall after first out_valid
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send({$urandom, $urandom, $urandom, 24'h0, 8'(k)}, 4'(k), 1'(k % 2), 1'b0);
            end
            begin
                int c = 0;
                while (!bus.out_valid && c < 50) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", 128'(bus.in_ready), 0);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Saturation: 9 error beats from count 1 saturates at 7
        for (int k = 0; k < 9; k++) send(128'h1 << (k * 7), 4'b1111, 1'b0, 1'b1);
        drain();
        check("sat_count", 128'(err_count), CNT_MAX);
        check("sat_sticky", 128'(err_sticky), 1);

        // Clear coincident with an error-beat handshake
        send(128'h0, 4'b0001, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_count", 128'(err_count), 0);
        check("clr_sticky", 128'(err_sticky), 0);
        drain();

        // Reset with two beats in flight
        send(128'h0, 4'b0100, 1'b0, 1'b1);
        drain();
        bus.out_ready = 1'b0;
        send(128'hAAAA, 4'b0000, 1'b0, 1'b1);
        send(128'h5555, 4'b0000, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 128'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 128'(bus.out_valid), 0);
        check("mid_rst_count", 128'(err_count), 0);
        check("mid_rst_in_ready", 128'(bus.in_ready), 1);
        repeat (5) @(posedge clk);
        #1;

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
                         1'($urandom), 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("final_queue_empty", 128'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_stream_chk.md
Name: parity_stream_chk

Overview:
- Streaming, pipelined per-lane parity generator/checker. Splits a wide data word into fixed-width lanes.
- Computes even or odd parity per lane. Optionally compares it against supplied parity bits and flags per-lane errors.
- Valid/ready handshake on both sides with full backpressure, one beat per cycle.
- Sits between the wide datapath registers and downstream consumers. Replaces fixed-width, free-running parity reduction.

Parameters:
- DATA_WIDTH, 1024, data word width in bits; must be an integer multiple of LANE_WIDTH.
- LANE_WIDTH, 64, bits per parity lane.
- CNT_WIDTH, 16, width of the saturating error-beat counter.
- Derived NUM_LANES = DATA_WIDTH/LANE_WIDTH. Lane i = in_data[i*LANE_WIDTH +: LANE_WIDTH].

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  DATA_WIDTH  input data word
- in_par  in  NUM_LANES  expected parity per lane (used only when check_en=1)
- mode_odd  in  1  0=even parity, 1=odd parity; sampled per beat
- check_en  in  1  1=compare against in_par; sampled per beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  DATA_WIDTH  data passed through unchanged
- out_par  out  NUM_LANES  computed parity per lane
- out_err  out  NUM_LANES  per-lane mismatch flags
- err_sticky  out  1  set by any error beat; held until cleared
- err_count  out  CNT_WIDTH  number of error beats delivered, saturating
- clr_err  in  1  synchronous clear of err_sticky and err_count

Behaviour:
- Reset (rst=1 at a clock edge):
  - Stage valids v1 and v2 go to 0.
  - out_data, out_par, out_err, err_count and err_sticky go to 0.
  - in_ready=0 while rst is high; out_valid=0.
  - In-flight beats are discarded and never emitted.
- Pipeline structure:
  - Two register stages.
  - S1 captures in_data, in_par, mode_odd and check_en on input handshake (in_valid && in_ready).
  - S2 holds the result that drives the out_* ports.
- Advance rules:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1 && !rst; it is combinational from out_ready and the valids.
  - Throughput is one beat per cycle with no bubbles when out_ready=1.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles, if unstalled.
- Stall: while out_valid && !out_ready, every out_* signal holds stable. S1 keeps filling if empty. There is no loss, duplication or reordering.
- Arithmetic (registered into S2):
  - out_par[i] = XOR-reduce(lane i) XOR mode_odd of that beat.
  - out_err[i] = check_en ? (out_par[i] != in_par[i]) : 0.
- Mode per beat: mode_odd and check_en travel with their beat. Changing them mid-stream affects only beats accepted afterwards.
- Error beat: a beat is an error beat if out_err is nonzero. It is counted at the output handshake (out_valid && out_ready), exactly once, even after a stall.
- Counter:
  - err_count increments by 1 per error beat.
  - It saturates at 2^CNT_WIDTH-1 and does not wrap.
  - err_sticky is set on the same edge.
- clr_err: has priority over a simultaneous error event. That cycle ends with err_count=0 and err_sticky=0, and the coincident event is not counted. clr_err does not affect the datapath.
- out_par and out_err are valid only while out_valid=1. When v2=0 they hold their last values.

Test Plan:
- Bench config for all scenarios: DATA_WIDTH=128, LANE_WIDTH=32 (4 lanes), CNT_WIDTH=3.
- Even generate: in_data=128'h1, mode_odd=0, check_en=0, accepted at edge N → out_valid after edge N+1, out_par=4'b0001, out_err=0, out_data=128'h1.
- Odd mode: in_data=0, mode_odd=1 → out_par=4'b1111. Next beat in_data=128'hF (lane0 has 4 ones), mode_odd=0 → out_par=4'b0000.
- Check: lane0=32'h3, other lanes 0, mode_odd=0, in_par=4'b0001, check_en=1 → out_err=4'b0001. After handshake err_count=1, err_sticky=1. Same beat with check_en=0 → out_err=0, count unchanged.
- Backpressure: 5 back-to-back beats D0..D4, out_ready=0 for 3 cycles after the first out_valid → in_ready falls with 2 beats held. All 5 beats emerge in order D0..D4, each exactly once. Stalled outputs stay stable.
- Saturation/clear: 9 error beats → err_count=7 (saturated). clr_err asserted on the same cycle as an error-beat handshake → err_count=0, err_sticky=0.
- Reset mid-stream: rst for 1 cycle with 2 beats in flight → next cycle out_valid=0, err_count=0. in_ready=0 during rst and 1 the cycle after. Neither in-flight beat is ever output.
